s2p_lanes: RTL and testbench

Parametrised serial-to-parallel converter and successor to the single-lane S2P block. It assembles a DW-bit word from LANES parallel serial lines, one beat per qualified cycle, with MSB-first or LSB-first bit ordering selected per frame. The assembled word is presented on a valid/ready output holding register. Overrun and framing errors are captured in sticky flags. It sits between serial front-ends (SPI-like or ADC lanes) and word-oriented datapaths.

---
 rtl/s2p_lanes.sv | 124 ++++++++++++
 tb/tb_s2p_lanes.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_lanes.sv
// Multi-lane serial-to-parallel converter: assembles DW-bit words from LANES serial
// lines, with per-frame bit order, a valid/ready output slot and sticky error flags.
module s2p_lanes #(
    parameter int unsigned DW    = 22,
    parameter int unsigned LANES = 1,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s2p_start,
    input  logic             s2p_msb_first,
    input  logic [LANES-1:0] s2p_din,
    input  logic             s2p_din_vld,
    output logic [DW-1:0]    s2p_dout,
    output logic             s2p_dout_vld,
    input  logic             s2p_dout_rdy,
    output logic             s2p_busy,
    output logic             s2p_overrun,
    output logic             s2p_frm_err,
    input  logic             s2p_err_clr
);

    localparam int unsigned N = DW / LANES;

    if (LANES < 1 || LANES > DW || (DW % LANES) != 0 || N >= (2 ** AW)) begin : g_param_check
        $error("s2p_lanes: DW must be a multiple of LANES and AW must hold DW/LANES");
    end

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            msb_q, msb_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            vld_q, vld_d;
    logic            ovr_q, ovr_d;
    logic            frm_q, frm_d;

    logic [DW-1:0]   din_ext;
    logic [DW-1:0]   shifted;
    logic            busy;
    logic            last;
    logic            beat;

    always_comb begin
        din_ext = '0;
        din_ext[LANES-1:0] = s2p_din;
    end

    // Shifts written as whole-word operations so LANES == DW needs no special case.
    assign shifted = msb_q ? ((shreg_q << LANES) | din_ext)
                           : ((shreg_q >> LANES) | (din_ext << (DW - LANES)));

    assign busy = (state_q == BUSY);
    assign last = busy && s2p_din_vld && (cnt_q == AW'(N - 1));
    // A start during a frame only counts as a beat when it coincides with the final one.
    assign beat = busy && s2p_din_vld && (!s2p_start || last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        msb_d   = msb_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        vld_d   = vld_q & ~s2p_dout_rdy;
        ovr_d   = ovr_q & ~s2p_err_clr;
        frm_d   = frm_q & ~s2p_err_clr;

        if (beat) begin
            shreg_d = shifted;
            cnt_d   = cnt_q + AW'(1);
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!vld_q || s2p_dout_rdy) begin
                    dout_d = shifted;
                    vld_d  = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end

        if (s2p_start) begin
            if (busy && !last) begin
                frm_d = 1'b1;
            end
            state_d = BUSY;
            cnt_d   = '0;
            msb_d   = s2p_msb_first;
            shreg_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
            shreg_q <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            frm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            frm_q   <= frm_d;
        end
    end

    assign s2p_dout     = dout_q;
    assign s2p_dout_vld = vld_q;
    assign s2p_busy     = busy;
    assign s2p_overrun  = ovr_q;
    assign s2p_frm_err  = frm_q;

endmodule

// File: tb/tb_s2p_lanes.sv
// Bench for s2p_lanes: three configurations share one stimulus stream and are checked
// every cycle against a positional-assembly model, plus literal directed expectations.
module tb_s2p_lanes;

    logic       clk = 1'b0;
    logic       rst, start, msb, dvld, rdy, clr;
    logic [1:0] din;

    logic [21:0] d22;
    logic        v22, b22, o22, f22;
    logic [7:0]  d8w;
    logic        v8w, b8w, o8w, f8w;
    logic [7:0]  d8;
    logic        v8, b8, o8, f8;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    s2p_lanes #(.DW(22), .LANES(1), .AW(5)) u22 (
        .clk(clk), .rst(rst), .s2p_start(start), .s2p_msb_first(msb),
        .s2p_din(din[0]), .s2p_din_vld(dvld), .s2p_dout(d22), .s2p_dout_vld(v22),
        .s2p_dout_rdy(rdy), .s2p_busy(b22), .s2p_overrun(o22), .s2p_frm_err(f22),
        .s2p_err_clr(clr));

    s2p_lanes #(.DW(8), .LANES(2), .AW(3)) u8w (
        .clk(clk), .rst(rst), .s2p_start(start), .s2p_msb_first(msb),
        .s2p_din(din), .s2p_din_vld(dvld), .s2p_dout(d8w), .s2p_dout_vld(v8w),
        .s2p_dout_rdy(rdy), .s2p_busy(b8w), .s2p_overrun(o8w), .s2p_frm_err(f8w),
        .s2p_err_clr(clr));

    s2p_lanes #(.DW(8), .LANES(1), .AW(4)) u8 (
        .clk(clk), .rst(rst), .s2p_start(start), .s2p_msb_first(msb),
        .s2p_din(din[0]), .s2p_din_vld(dvld), .s2p_dout(d8), .s2p_dout_vld(v8),
        .s2p_dout_rdy(rdy), .s2p_busy(b8), .s2p_overrun(o8), .s2p_frm_err(f8),
        .s2p_err_clr(clr));

    typedef struct packed {
        bit          busy;
        int          cnt;
        bit          msb;
        logic [31:0] acc;
        logic [31:0] dout;
        bit          vld;
        bit          ovr;
        bit          frm;
    } mdl_t;

    mdl_t m22 = '0;
    mdl_t m8w = '0;
    mdl_t m8  = '0;

    // Each beat is placed directly at its final bit position in the word.
    function automatic mdl_t mstep(mdl_t m, int dw, int lanes, bit r, bit st, bit mi,
                                   logic [1:0] dn, bit dv, bit rd, bit cl);
        mdl_t n = m;
        int nb = dw / lanes;
        bit lst;
        logic [31:0] d, word;
        if (r) return '0;
        d = 32'(dn) & ((32'd1 << lanes) - 32'd1);
        if (m.vld && rd) n.vld = 0;
        if (cl) begin n.ovr = 0; n.frm = 0; end
        lst = m.busy && dv && (m.cnt == nb - 1);
        if (m.busy && dv && (!st || lst)) begin
            if (m.msb) word = m.acc | (d << (dw - lanes * (m.cnt + 1)));
            else       word = m.acc | (d << (lanes * m.cnt));
            n.acc = word;
            n.cnt = m.cnt + 1;
            if (lst) begin
                if (!m.vld || rd) begin n.dout = word; n.vld = 1; end
                else n.ovr = 1;
                n.busy = 0; n.cnt = 0; n.acc = '0;
            end
        end
        if (st) begin
            if (m.busy && !lst) n.frm = 1;
            n.busy = 1; n.cnt = 0; n.acc = '0; n.msb = mi;
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m22 = mstep(m22, 22, 1, rst, start, msb, din, dvld, rdy, clr);
        m8w = mstep(m8w, 8, 2, rst, start, msb, din, dvld, rdy, clr);
        m8  = mstep(m8, 8, 1, rst, start, msb, din, dvld, rdy, clr);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("u22.dout", 32'(d22), m22.dout);
            chk("u22.vld",  32'(v22), 32'(m22.vld));
            chk("u22.busy", 32'(b22), 32'(m22.busy));
            chk("u22.ovr",  32'(o22), 32'(m22.ovr));
            chk("u22.frm",  32'(f22), 32'(m22.frm));
            chk("u8w.dout", 32'(d8w), m8w.dout);
            chk("u8w.vld",  32'(v8w), 32'(m8w.vld));
            chk("u8w.busy", 32'(b8w), 32'(m8w.busy));
            chk("u8w.ovr",  32'(o8w), 32'(m8w.ovr));
            chk("u8w.frm",  32'(f8w), 32'(m8w.frm));
            chk("u8.dout",  32'(d8), m8.dout);
            chk("u8.vld",   32'(v8), 32'(m8.vld));
            chk("u8.busy",  32'(b8), 32'(m8.busy));
            chk("u8.ovr",   32'(o8), 32'(m8.ovr));
            chk("u8.frm",   32'(f8), 32'(m8.frm));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic startf(bit m);
        start = 1'b1;
        msb   = m;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(logic [1:0] v);
        din  = v;
        dvld = 1'b1;
        tick();
        dvld = 1'b0;
    endtask

    task automatic send_bits(logic [7:0] v, int hi, int lo);
        for (int i = hi; i >= lo; i--) beat({1'b0, v[i]});
    endtask

    initial begin
        logic [21:0] w22;
        rst = 1'b1; start = 0; msb = 0; dvld = 0; rdy = 0; clr = 0; din = '0;
        tick();
        tick();
        chk_en = 1;
        chk("reset.dout", 32'(d22), 32'h0);
        chk("reset.vld",  32'(v8), 32'h0);
        rst = 1'b0;

        // 22-bit MSB-first frame
        w22 = 22'h2A5A5C;
        rdy = 1'b1;
        startf(1'b1);
        chk("t1.busy", 32'(b22), 32'h1);
        for (int i = 21; i >= 1; i--) beat({1'b0, w22[i]});
        chk("t1.vld_early", 32'(v22), 32'h0);
        beat({1'b0, w22[0]});
        chk("t1.dout", 32'(d22), 32'h2A5A5C);
        chk("t1.vld",  32'(v22), 32'h1);
        chk("t1.busy_after", 32'(b22), 32'h0);
        tick();
        chk("t1.vld_drop", 32'(v22), 32'h0);

        // two-lane LSB-first frame with gaps
        do_reset();
        startf(1'b0);
        beat(2'b01); tick();
        beat(2'b10); tick(); tick();
        beat(2'b11); tick();
        chk("t2.busy_mid", 32'(b8w), 32'h1);
        chk("t2.vld_mid",  32'(v8w), 32'h0);
        beat(2'b00);
        chk("t2.dout", 32'(d8w), 32'h39);
        chk("t2.vld",  32'(v8w), 32'h1);

        // overrun with consumer stalled
        do_reset();
        rdy = 1'b0;
        startf(1'b1); send_bits(8'hA5, 7, 0);
        startf(1'b1); send_bits(8'h3C, 7, 0);
        chk("t3.dout", 32'(d8), 32'hA5);
        chk("t3.vld",  32'(v8), 32'h1);
        chk("t3.ovr",  32'(o8), 32'h1);
        rdy = 1'b1; tick(); rdy = 1'b0;
        chk("t3.vld_drop", 32'(v8), 32'h0);
        chk("t3.dout_hold", 32'(d8), 32'hA5);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t3.ovr_clr", 32'(o8), 32'h0);

        // restart mid-frame
        do_reset();
        rdy = 1'b1;
        startf(1'b1);
        beat(2'b01); beat(2'b01); beat(2'b01);
        startf(1'b1);
        send_bits(8'hF0, 7, 0);
        chk("t4.frm",  32'(f8), 32'h1);
        chk("t4.dout", 32'(d8), 32'hF0);
        chk("t4.vld",  32'(v8), 32'h1);

        // start on the last beat, second word loads as the first is accepted
        do_reset();
        rdy = 1'b1;
        startf(1'b1);
        send_bits(8'h5A, 7, 1);
        start = 1'b1; msb = 1'b1;
        beat({1'b0, 1'b0});
        start = 1'b0;
        chk("t5.dout1", 32'(d8), 32'h5A);
        chk("t5.vld1",  32'(v8), 32'h1);
        chk("t5.busy",  32'(b8), 32'h1);
        rdy = 1'b0;
        send_bits(8'hC3, 7, 1);
        chk("t5.vld_hold", 32'(v8), 32'h1);
        rdy = 1'b1;
        beat({1'b0, 1'b1});
        chk("t5.dout2", 32'(d8), 32'hC3);
        chk("t5.vld2",  32'(v8), 32'h1);
        chk("t5.frm",   32'(f8), 32'h0);
        chk("t5.ovr",   32'(o8), 32'h0);

        // reset mid-frame with a held word
        do_reset();
        rdy = 1'b0;
        startf(1'b1); send_bits(8'h11, 7, 0);
        startf(1'b1);
        beat(2'b01); beat(2'b00); beat(2'b01);
        chk("t6.vld_pre", 32'(v8), 32'h1);
        do_reset();
        chk("t6.dout", 32'(d8), 32'h0);
        chk("t6.vld",  32'(v8), 32'h0);
        chk("t6.busy", 32'(b8), 32'h0);
        rdy = 1'b1;
        startf(1'b1); send_bits(8'h96, 7, 0);
        chk("t6.dout_new", 32'(d8), 32'h96);
        chk("t6.vld_new",  32'(v8), 32'h1);

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
